// File: rtl/collector.sv
// collector: receive endpoint of the NoC AXI-stream link. Validates each
// packet header, buffers accepted flits (payload + tlast) in a show-ahead
// FIFO for the compute unit, and discards bad packets whole while counting them.
module collector #(
  parameter int DATAW     = 512,
  parameter int BYTEW     = 8,
  parameter int IDW       = 32,
  parameter int DESTW     = 7,
  parameter int USERW     = 75,
  parameter int DATAUSERW = DATAW + USERW,
  parameter int MYNODE    = 0,
  parameter int DEPTH     = 64,
  parameter int CNTW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 axis_rx_tvalid,
  input  logic [DATAUSERW-1:0] axis_rx_tdata,
  input  logic [BYTEW-1:0]     axis_rx_tstrb,
  input  logic [BYTEW-1:0]     axis_rx_tkeep,
  input  logic [IDW-1:0]       axis_rx_tid,
  input  logic [DESTW-1:0]     axis_rx_tdest,
  input  logic [USERW-1:0]     axis_rx_tuser,
  input  logic                 axis_rx_tlast,
  output logic                 axis_rx_tready,
  input  logic                 data_fifo_ren,
  output logic [DATAW-1:0]     data_fifo_rdata,
  output logic                 data_fifo_rlast,
  output logic                 data_fifo_empty,
  output logic [CNTW-1:0]      pkt_count,
  output logic [CNTW-1:0]      drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   pkt_count_q, pkt_count_d;
  logic [CNTW-1:0]   drop_count_q, drop_count_d;
  logic              run_q, run_d;

  logic [DATAW:0]    mem [DEPTH];
  logic [DATAW:0]    head;

  logic              full;
  logic              empty;
  logic              hdr_ok;
  logic              beat;
  logic              push;
  logic              pop;
  logic              pkt_inc;
  logic              drop_inc;

  // Only the two type bits of the embedded user field matter here; the
  // sideband fields are accepted for protocol completeness and ignored.
  logic unused_bits;
  assign unused_bits = ^{axis_rx_tstrb, axis_rx_tkeep, axis_rx_tid, axis_rx_tuser,
                         axis_rx_tdata[DATAUSERW-1:DATAW+11],
                         axis_rx_tdata[DATAW+8:DATAW]};

  // FIFO status, header check and the ready/beat handshake.
  // run_q holds tready low from reset until the first clock after release.
  always_comb begin
    empty          = (wr_ptr_q == rd_ptr_q);
    full           = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    hdr_ok         = (axis_rx_tdata[DATAW+10:DATAW+9] == 2'b10) &&
                     (axis_rx_tdest == DESTW'(MYNODE));
    axis_rx_tready = run_q & ((state_q == S_DROP) | ~full);
    beat           = axis_rx_tvalid & axis_rx_tready;
    pop            = data_fifo_ren & ~empty;
  end

  // Packet FSM: decides per beat whether to push, and which counter to bump.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    if (beat) begin
      unique case (state_q)
        S_HDR: begin
          if (hdr_ok) begin
            push = 1'b1;
            if (axis_rx_tlast) pkt_inc = 1'b1;
            else               state_d = S_PASS;
          end else begin
            drop_inc = 1'b1;
            if (!axis_rx_tlast) state_d = S_DROP;
          end
        end
        S_PASS: begin
          push = 1'b1;
          if (axis_rx_tlast) begin
            pkt_inc = 1'b1;
            state_d = S_HDR;
          end
        end
        S_DROP: begin
          if (axis_rx_tlast) state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  // Next-state for pointers and saturating statistics counters.
  always_comb begin
    run_d        = 1'b1;
    wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    if (pkt_inc && (pkt_count_q != {CNTW{1'b1}}))
      pkt_count_d = pkt_count_q + CNTW'(1);
    if (drop_inc && (drop_count_q != {CNTW{1'b1}}))
      drop_count_d = drop_count_q + CNTW'(1);
  end

  // State register; reset flushes the FIFO, including any partial packet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_HDR;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      run_q        <= run_d;
    end
  end

  // FIFO storage: {tlast, payload}, written on the accepting beat.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= {axis_rx_tlast, axis_rx_tdata[DATAW-1:0]};
  end

  // Show-ahead head entry, forced to zero while the FIFO is empty.
  always_comb begin
    head            = mem[rd_ptr_q[AW-1:0]];
    data_fifo_empty = empty;
    data_fifo_rdata = empty ? '0   : head[DATAW-1:0];
    data_fifo_rlast = empty ? 1'b0 : head[DATAW];
    pkt_count       = pkt_count_q;
    drop_count      = drop_count_q;
  end

endmodule
